async_fifo_wr_arbiter: RTL and testbench



---
 rtl/async_fifo_pkg.sv | 20 ++
 rtl/rr_pick.sv | 28 ++
 rtl/async_fifo_wr_arbiter.sv | 149 ++++++++++++++
 tb/tb_async_fifo_wr_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared types and constants for the asynchronous FIFO write-side arbiter.
package async_fifo_pkg;

    // Arbiter FSM states.
    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // Width of the per-burst beat counter (BURST_LEN is at most 255).
    localparam int unsigned BEAT_W = 8;
    // Width of each per-requester statistics counter.
    localparam int unsigned STAT_W = 16;

    // Increment with wrap at n-1 -> 0.
    function automatic int unsigned wrap_inc(input int unsigned x, input int unsigned n);
        return (x + 1 >= n) ? 0 : x + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: finds the first set bit of req,
// searching upward from start and wrapping from N-1 back to 0.
module rr_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] start,
    output logic [IDW-1:0] index,
    output logic           found
);

    // Scan all offsets from start; the first hit wins.
    always_comb begin
        int unsigned j;
        index = start;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(start) + k) % N;
            if (!found && req[j]) begin
                found = 1'b1;
                index = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the single write port of an asynchronous
// FIFO among NUM_REQ requesters in the wr_clk domain. Never writes while the
// FIFO is full. Define WR_ARB_STATS_EN to add per-requester beat counters.
module async_fifo_wr_arbiter
    import async_fifo_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BURST_LEN = 4,
    localparam int unsigned ID_W     = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     wr_clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_write_en,
    output logic [WIDTH-1:0]         fifo_write_data,
    output logic [ID_W-1:0]          grant_id,
`ifdef WR_ARB_STATS_EN
    output logic [NUM_REQ*STAT_W-1:0] beat_count,
`endif
    output logic                     burst_active
);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0] beats_q, beats_d;

    logic [ID_W-1:0]   sel;
    logic              sel_found;
    logic [WIDTH-1:0]  data_arr [NUM_REQ];

    rr_pick #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_rr_pick (
        .req   (req_valid),
        .start (rr_ptr_q),
        .index (sel),
        .found (sel_found)
    );

    // Unpack requester data so the write mux is a simple array index.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Next-state, grant and handshake logic.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        beats_d   = beats_q;
        req_ready = '0;
        grant_id  = rr_ptr_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (sel_found) begin
                    grant_id = sel;
                    if (!fifo_full) begin
                        req_ready[sel] = 1'b1;
                        if (BURST_LEN > 1) begin
                            state_d = ARB_BURST;
                            owner_d = sel;
                            beats_d = BEAT_W'(1);
                        end else begin
                            rr_ptr_d = ID_W'(wrap_inc(32'(sel), NUM_REQ));
                        end
                    end
                end
            end
            ARB_BURST: begin
                grant_id = owner_q;
                if (req_valid[owner_q]) begin
                    // A full stall holds everything and is not charged to the burst.
                    if (!fifo_full) begin
                        req_ready[owner_q] = 1'b1;
                        beats_d = beats_q + BEAT_W'(1);
                        if ({1'b0, beats_q} + 9'd1 == 9'(BURST_LEN)) begin
                            state_d  = ARB_IDLE;
                            rr_ptr_d = ID_W'(wrap_inc(32'(owner_q), NUM_REQ));
                        end
                    end
                end else begin
                    // Owner dropped: end the burst early without writing.
                    state_d  = ARB_IDLE;
                    rr_ptr_d = ID_W'(wrap_inc(32'(owner_q), NUM_REQ));
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // No handshake while reset is held, even mid-burst.
        if (!reset) begin
            req_ready = '0;
        end
    end

    // FIFO write port driven straight from the current grant.
    always_comb begin
        fifo_write_en   = |req_ready;
        fifo_write_data = data_arr[grant_id];
        burst_active    = (state_q == ARB_BURST);
    end

    // Arbiter state registers with synchronous active-low reset.
    always_ff @(posedge wr_clk) begin
        if (!reset) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            beats_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            beats_q  <= beats_d;
        end
    end

`ifdef WR_ARB_STATS_EN
    logic [STAT_W-1:0] cnt_q [NUM_REQ];

    // Per-requester accepted-beat counters, wrapping at 2^STAT_W.
    always_ff @(posedge wr_clk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!reset) begin
                cnt_q[i] <= '0;
            end else if (req_ready[i]) begin
                cnt_q[i] <= cnt_q[i] + STAT_W'(1);
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            beat_count[i*STAT_W +: STAT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed bench for async_fifo_wr_arbiter: one instance with BURST_LEN=4 and
// one with BURST_LEN=1. Covers WR_ARB_STATS_EN when that macro is defined.
module tb_async_fifo_wr_arbiter;

    logic        wr_clk = 1'b0;
    logic        reset;

    logic [3:0]  va, ra, vb, rb;
    logic [31:0] da, db;
    logic        fa, fb, wa, wb, ba, bb;
    logic [7:0]  wda, wdb;
    logic [1:0]  ga, gb;
`ifdef WR_ARB_STATS_EN
    logic [63:0] bca, bcb;
`endif

    int total = 0;
    int bad   = 0;

    always #5 wr_clk = ~wr_clk;

    async_fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .WIDTH     (8),
        .BURST_LEN (4)
    ) dut_a (
        .wr_clk          (wr_clk),
        .reset           (reset),
        .req_valid       (va),
        .req_data        (da),
        .req_ready       (ra),
        .fifo_full       (fa),
        .fifo_write_en   (wa),
        .fifo_write_data (wda),
        .grant_id        (ga),
`ifdef WR_ARB_STATS_EN
        .beat_count      (bca),
`endif
        .burst_active    (ba)
    );

    async_fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .WIDTH     (8),
        .BURST_LEN (1)
    ) dut_b (
        .wr_clk          (wr_clk),
        .reset           (reset),
        .req_valid       (vb),
        .req_data        (db),
        .req_ready       (rb),
        .fifo_full       (fb),
        .fifo_write_en   (wb),
        .fifo_write_data (wdb),
        .grant_id        (gb),
`ifdef WR_ARB_STATS_EN
        .beat_count      (bcb),
`endif
        .burst_active    (bb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; inputs are driven and sampled there.
    task automatic step;
        @(negedge wr_clk);
    endtask

    initial begin
        reset = 1'b0;
        va = 4'b1111; vb = 4'b1111; fa = 1'b0; fb = 1'b0;
        da = 32'h33221100; db = 32'hD3C2B1A0;

        // Reset held: no handshake even with all valid.
        step; #1;
        chk("rst_ready_a", 32'(ra), 32'h0);
        chk("rst_we_a", 32'(wa), 32'h0);
        chk("rst_ready_b", 32'(rb), 32'h0);
        step;
        reset = 1'b1; va = 4'b0000; vb = 4'b0000; #1;
        chk("rst_grant_a", 32'(ga), 32'h0);
        chk("rst_burst_a", 32'(ba), 32'h0);
        chk("rst_we_a_idle", 32'(wa), 32'h0);

        // Single requester 2: two back-to-back bursts of four beats.
        for (int k = 0; k < 8; k++) begin
            step;
            va = 4'b0100; da[16 +: 8] = 8'(8'h10 + k); #1;
            chk("single_we", 32'(wa), 32'h1);
            chk("single_data", 32'(wda), 32'(8'h10 + k));
            chk("single_grant", 32'(ga), 32'h2);
            chk("single_ready", 32'(ra), 32'h4);
            chk("single_burst", 32'(ba), (k % 4 != 0) ? 32'h1 : 32'h0);
        end
        step;
        va = 4'b0000; #1;
        chk("single_after_grant", 32'(ga), 32'h3);
        chk("single_after_we", 32'(wa), 32'h0);

        // Round-robin with BURST_LEN=1 on the second instance.
        for (int k = 0; k < 8; k++) begin
            step;
            vb = 4'b1111; #1;
            chk("rr_grant", 32'(gb), 32'(k % 4));
            chk("rr_ready", 32'(rb), 32'(1 << (k % 4)));
            chk("rr_we", 32'(wb), 32'h1);
            chk("rr_data", 32'(wdb), 32'(8'hA0 + 8'h11 * (k % 4)));
            chk("rr_burst", 32'(bb), 32'h0);
        end
        step;
        fb = 1'b1; #1;
        chk("rr_full_we", 32'(wb), 32'h0);
        chk("rr_full_grant", 32'(gb), 32'h0);
        step;
        fb = 1'b0; #1;
        chk("rr_resume_grant", 32'(gb), 32'h0);
        step;
        vb = 4'b0000;

        // Burst from req 1 with a three-cycle full stall after beat 2.
        va = 4'b0010; da[8 +: 8] = 8'h51; #1;
        chk("full_b1_we", 32'(wa), 32'h1);
        chk("full_b1_grant", 32'(ga), 32'h1);
        step;
        da[8 +: 8] = 8'h52; #1;
        chk("full_b2_we", 32'(wa), 32'h1);
        for (int k = 0; k < 3; k++) begin
            step;
            fa = 1'b1; da[8 +: 8] = 8'h53; #1;
            chk("full_stall_we", 32'(wa), 32'h0);
            chk("full_stall_ready", 32'(ra), 32'h0);
            chk("full_stall_grant", 32'(ga), 32'h1);
            chk("full_stall_burst", 32'(ba), 32'h1);
        end
        step;
        fa = 1'b0; #1;
        chk("full_b3_we", 32'(wa), 32'h1);
        chk("full_b3_data", 32'(wda), 32'h53);
        step;
        da[8 +: 8] = 8'h54; #1;
        chk("full_b4_we", 32'(wa), 32'h1);
        chk("full_b4_burst", 32'(ba), 32'h1);
        step;
        va = 4'b1111; fa = 1'b1; #1;
        chk("full_rrptr_grant", 32'(ga), 32'h2);
        chk("full_idle_we", 32'(wa), 32'h0);
        chk("full_idle_burst", 32'(ba), 32'h0);

        // Early drop: req 3 owns, then deasserts while req 0 is waiting.
        step;
        fa = 1'b0; va = 4'b1000; da[24 +: 8] = 8'h73; #1;
        chk("drop_b1_grant", 32'(ga), 32'h3);
        chk("drop_b1_we", 32'(wa), 32'h1);
        step;
        va = 4'b0001; da[0 +: 8] = 8'h40; #1;
        chk("drop_cycle_we", 32'(wa), 32'h0);
        chk("drop_cycle_grant", 32'(ga), 32'h3);
        step;
        #1;
        chk("drop_next_grant", 32'(ga), 32'h0);
        chk("drop_next_we", 32'(wa), 32'h1);
        chk("drop_next_data", 32'(wda), 32'h40);
        step;
        va = 4'b0000; #1;
        chk("drop_end_we", 32'(wa), 32'h0);

        // Reset during beat 2 of a req 1 burst.
        step;
        va = 4'b0010; #1;
        chk("rmid_b1_grant", 32'(ga), 32'h1);
        chk("rmid_b1_we", 32'(wa), 32'h1);
        step;
        reset = 1'b0; #1;
        chk("rmid_ready", 32'(ra), 32'h0);
        chk("rmid_we", 32'(wa), 32'h0);
        step;
        reset = 1'b1; va = 4'b1111; #1;
        chk("rmid_after_grant", 32'(ga), 32'h0);
        chk("rmid_after_ready", 32'(ra), 32'h1);
        chk("rmid_after_burst", 32'(ba), 32'h0);

`ifdef WR_ARB_STATS_EN
        step;
        reset = 1'b0; va = 4'b0000; vb = 4'b0000;
        step;
        reset = 1'b1; #1;
        chk("stats_rst", bca[31:0], 32'h0);
        va = 4'b0001;
        for (int k = 0; k < 70000; k++) begin
            step;
        end
        va = 4'b0000; #1;
        chk("stats_req0", 32'(bca[15:0]), 32'd4464);
        chk("stats_req1", 32'(bca[31:16]), 32'h0);
        chk("stats_req23", bca[63:32], 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
